// File: rtl/hazard_controller_if.sv
// Pipeline hazard bus between the datapath and hazard_controller.
// master: the hazard controller (reads pipeline register fields, drives stall/flush/forward).
// slave : the datapath (drives register fields, consumes controls).
// Signals: Rs1D/Rs2D, Rs1E/Rs2E, RdE/RdM/RdW, RegWriteE/M/W, ResultSrcE, PCSrcE,
//          MemAccessM, ClearCount in; StallF/D/E/M, FlushD/E/W, ForwardAE/BE, StallCount out.
interface hazard_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MemAccessM;
    logic             ClearCount;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic [CNT_W-1:0] StallCount;

    modport master (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, ClearCount,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, StallCount
    );

    modport slave (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, ClearCount,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, StallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// Central pipeline sequencer for the 5-stage RISC-V core: stall/flush of the
// pipeline registers, EX operand forwarding, multi-cycle data-memory hold and
// a saturating stall-cycle counter.
// Ports: clk (rising edge), rst (async, active-high), hif (hazard bus, master side).
// Stall/flush/forward outputs are combinational from state + inputs; StallCount is registered.
module hazard_controller #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_controller_if.master hif
);

    // Wait counter only has to hold MEM_LAT-2.
    localparam int unsigned WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              served_q, served_d;

    logic entry;
    logic mem_stall;
    logic load_use;

    // Writes are implied by ResultSrcE==01 (a load always writes).
    logic unused_regwrite_e;
    assign unused_regwrite_e = hif.RegWriteE;

    // MEM priority over WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            served_q <= served_d;
        end
    end

    // Next state and hazard outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        served_d      = 1'b0;
        hif.StallF    = 1'b0;
        hif.StallD    = 1'b0;
        hif.StallE    = 1'b0;
        hif.StallM    = 1'b0;
        hif.FlushD    = 1'b0;
        hif.FlushE    = 1'b0;
        hif.FlushW    = 1'b0;
        hif.ForwardAE = fwd_sel(hif.Rs1E, hif.RdM, hif.RegWriteM, hif.RdW, hif.RegWriteW);
        hif.ForwardBE = fwd_sel(hif.Rs2E, hif.RdM, hif.RegWriteM, hif.RdW, hif.RegWriteW);

        // While reset is held a pending MemAccessM must not re-raise the stall.
        entry     = ~rst & (state_q == ST_RUN) & hif.MemAccessM & ~served_q & (MEM_LAT != 0);
        mem_stall = (state_q == ST_WAIT) | entry;
        load_use  = (hif.ResultSrcE == 2'b01) & (hif.RdE != 5'd0) &
                    ((hif.RdE == hif.Rs1D) | (hif.RdE == hif.Rs2D));

        case (state_q)
            ST_RUN: begin
                if (entry) begin
                    if (MEM_LAT > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_W'(MEM_LAT - 2);
                    end else begin
                        served_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    state_d  = ST_RUN;
                    served_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Memory hold freezes everything; branch flush beats load-use stall.
        if (mem_stall) begin
            hif.StallF = 1'b1;
            hif.StallD = 1'b1;
            hif.StallE = 1'b1;
            hif.StallM = 1'b1;
            hif.FlushW = 1'b1;
        end else if (hif.PCSrcE) begin
            hif.FlushD = 1'b1;
            hif.FlushE = 1'b1;
        end else if (load_use) begin
            hif.StallF = 1'b1;
            hif.StallD = 1'b1;
            hif.FlushE = 1'b1;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hif.StallCount <= '0;
        end else if (hif.ClearCount) begin
            hif.StallCount <= '0;
        end else if (hif.StallF && (hif.StallCount != '1)) begin
            hif.StallCount <= hif.StallCount + CNT_W'(1);
        end
    end

endmodule
